// File: rtl/rs232_fifo_transmitter_pkg.sv
// rs232_defs: shared RS232 state encodings, frame levels and bit timing; PARITY state exists only with RS232_TX_PARITY_EN
package rs232_defs;
`ifdef RS232_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;
`endif
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  function automatic int bit_ticks(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction
endpackage

// File: rtl/rs232_fifo_transmitter_if.sv
// rs232_fifo_transmitter_if: FIFO-side handshake and serial outputs of the transmitter
interface rs232_fifo_transmitter_if #(parameter int DATA_WIDTH = 8) ();
  logic enable;
  logic fifo_ready;
  logic fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic fifo_pop;
  logic tx;
  logic busy;
  logic frame_done;
  modport master(output enable, fifo_ready, fifo_empty, fifo_data, input fifo_pop, tx, busy, frame_done);
  modport slave(input enable, fifo_ready, fifo_empty, fifo_data, output fifo_pop, tx, busy, frame_done);
endinterface

// File: rtl/rs232_fifo_transmitter_baud.sv
// baud_tick_generator: 16-bit bit-period counter, tick on the last cycle of every bit
module baud_tick_generator
  import rs232_defs::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(bit_ticks(CLOCK_FREQ, BAUD_RATE) - 1);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == LAST;
    cnt_d = (restart || tick) ? '0 : cnt_q + 16'd1;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rs232_fifo_transmitter.sv
// rs232_fifo_transmitter: pops one FIFO word per frame and sends it 8N1; RS232_TX_PARITY_EN adds an even-parity bit
module rs232_fifo_transmitter
  import rs232_defs::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_WIDTH = 8
) (
  input logic clock,
  input logic clear,
  rs232_fifo_transmitter_if.slave bus
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] bit_q, bit_d;
  logic tx_q, tx_d, tick, restart, last_bit;
`ifdef RS232_TX_PARITY_EN
  logic par_q, par_d;
`endif
  baud_tick_generator #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_baud (
    .clock(clock), .clear(clear), .restart(restart), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    tx_d = STOP_LEVEL;
`ifdef RS232_TX_PARITY_EN
    par_d = par_q;
`endif
    restart = state_q == IDLE || state_q == POP || state_q == LATCH;
    last_bit = bit_q == CW'(DATA_WIDTH - 1);
    bus.fifo_pop = state_q == POP;
    bus.busy = state_q != IDLE;
    bus.frame_done = state_q == STOP && tick;
    case (state_q)
      IDLE: state_d = (bus.enable && bus.fifo_ready && !bus.fifo_empty) ? POP : IDLE;
      POP: state_d = LATCH;
      LATCH: begin
        shift_d = bus.fifo_data;
        bit_d = '0;
`ifdef RS232_TX_PARITY_EN
        par_d = ^bus.fifo_data;
`endif
        state_d = START;
      end
      START: begin
        tx_d = START_LEVEL;
        state_d = tick ? DATA : START;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + CW'(1);
`ifdef RS232_TX_PARITY_EN
          state_d = last_bit ? PARITY : DATA;
`else
          state_d = last_bit ? STOP : DATA;
`endif
        end
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        state_d = tick ? STOP : PARITY;
      end
`endif
      STOP: state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // tx is registered so the line is glitch-free and clear can force it high asynchronously
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tx_q <= STOP_LEVEL;
`ifdef RS232_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
`ifdef RS232_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign bus.tx = tx_q;
endmodule

// File: tb/tb_rs232_fifo_transmitter.sv
// tb_rs232_fifo_transmitter: FIFO model, tx line decoder with frame scoreboard, table-driven frames plus corner sequences
module tb_rs232_fifo_transmitter;
  localparam int BT = 434;
`ifdef RS232_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [7:0] data;
    logic [10:0] frame;
  } vec_t;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int n_vec = 0, n_bad = 0;
  int cyc = 0, pushed = 0, popped = 0, fd_cnt = 0, frames = 0, last_start = 0, last_gap = -1;
  logic [7:0] mem [256];
  logic [10:0] exp_q [$];

  rs232_fifo_transmitter_if #(.DATA_WIDTH(8)) bus ();
  rs232_fifo_transmitter #(.CLOCK_FREQ(50000000), .BAUD_RATE(115200), .DATA_WIDTH(8)) dut (
    .clock(clock), .clear(clear), .bus(bus)
  );

  always #5 clock = ~clock;

  assign bus.fifo_empty = (pushed == popped);
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.fifo_pop) begin
      bus.fifo_data <= mem[popped[7:0]];
      popped <= popped + 1;
    end
    if (bus.frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [10:0] f, input bit expect_it);
    mem[pushed[7:0]] = d;
    pushed++;
    if (expect_it) exp_q.push_back(f);
  endtask

  task automatic wait_frames(input int target, input string name);
    int t = 0;
    while (frames < target && t < 3 * NB * BT + 1000) begin
      @(negedge clock);
      t++;
    end
    check(name, frames, target);
  endtask

  // decodes each frame from tx, requiring every bit to hold its level for exactly BT cycles
  initial begin : mon
    logic prev, first;
    logic [10:0] fr;
    int st, prev_end;
    bit abort, shape;
    prev = 1'b1;
    prev_end = -100000;
    forever begin
      @(negedge clock);
      if (!clear && prev && !bus.tx) begin
        st = cyc;
        last_start = st;
        last_gap = st - prev_end;
        fr = '0;
        abort = 0;
        shape = 1;
        first = 1'b0;
        for (int k = 0; k < NB * BT; k++) begin
          if (k > 0) @(negedge clock);
          if (clear) begin
            abort = 1;
            break;
          end
          if (k % BT == 0) first = bus.tx;
          if (bus.tx != first) shape = 0;
          if (k % BT == BT / 2) fr[k / BT] = bus.tx;
        end
        if (abort) prev_end = -100000;
        else begin
          frames++;
          prev_end = st + NB * BT;
          check("bit_timing", int'(shape), 1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame: got 0x%0h expected no frame", fr);
          end else check("frame", int'(fr), int'(exp_q.pop_front()));
        end
      end
      prev = bus.tx;
    end
  end

  initial begin
    vec_t tv[7];
    int p0, f0, p1, fd0, bad_tx, bad_pop, bad_busy;
`ifdef RS232_TX_PARITY_EN
    tv[0] = '{8'h55, 11'b1_0_01010101_0};
    tv[1] = '{8'hA3, 11'b1_0_10100011_0};
    tv[2] = '{8'h0F, 11'b1_0_00001111_0};
    tv[3] = '{8'hFF, 11'b1_0_11111111_0};
    tv[4] = '{8'h07, 11'b1_1_00000111_0};
    tv[5] = '{8'h03, 11'b1_0_00000011_0};
    tv[6] = '{8'h00, 11'b1_0_00000000_0};
`else
    tv[0] = '{8'h55, 11'b0_1_01010101_0};
    tv[1] = '{8'hA3, 11'b0_1_10100011_0};
    tv[2] = '{8'h0F, 11'b0_1_00001111_0};
    tv[3] = '{8'hFF, 11'b0_1_11111111_0};
    tv[4] = '{8'h07, 11'b0_1_00000111_0};
    tv[5] = '{8'h03, 11'b0_1_00000011_0};
    tv[6] = '{8'h00, 11'b0_1_00000000_0};
`endif
    bus.enable = 1'b1;
    bus.fifo_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_tx", int'(bus.tx), 1);
    check("rst_pop", int'(bus.fifo_pop), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    clear = 1'b0;

    bad_tx = 0; bad_pop = 0; bad_busy = 0;
    repeat (10000) begin
      @(negedge clock);
      bad_tx += int'(!bus.tx);
      bad_pop += int'(bus.fifo_pop);
      bad_busy += int'(bus.busy);
    end
    check("empty_tx_low_cycles", bad_tx, 0);
    check("empty_pop_cycles", bad_pop, 0);
    check("empty_busy_cycles", bad_busy, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      p0 = cyc;
      f0 = frames;
      push(tv[i].data, tv[i].frame, 1);
      wait_frames(f0 + 1, "single_frame_seen");
      check("start_latency", last_start - p0, 4);
      check("single_pops", popped, pushed);
      check("single_frame_done", fd_cnt, i + 1);
      repeat (10) @(negedge clock);
      check("single_idle_busy", int'(bus.busy), 0);
    end

    f0 = frames;
    p1 = popped;
    @(negedge clock);
    push(tv[1].data, tv[1].frame, 1);
    push(tv[2].data, tv[2].frame, 1);
    wait_frames(f0 + 2, "b2b_frames_seen");
    check("b2b_gap", last_gap, 3);
    repeat (500) @(negedge clock);
    check("b2b_pops", popped - p1, 2);
    check("b2b_busy", int'(bus.busy), 0);

    f0 = frames;
    p1 = popped;
    @(negedge clock);
    push(tv[3].data, tv[3].frame, 1);
    push(tv[0].data, tv[0].frame, 1);
    repeat (4 + 4 * BT + 100) @(negedge clock);
    bus.enable = 1'b0;
    wait_frames(f0 + 1, "en_drop_frame_seen");
    repeat (2000) @(negedge clock);
    check("en_drop_pops", popped - p1, 1);
    check("en_drop_busy", int'(bus.busy), 0);
    bus.fifo_ready = 1'b0;
    bus.enable = 1'b1;
    repeat (200) @(negedge clock);
    check("not_ready_pops", popped - p1, 1);
    bus.fifo_ready = 1'b1;
    wait_frames(f0 + 2, "en_restore_frame_seen");
    check("en_restore_pops", popped - p1, 2);

    f0 = frames;
    @(negedge clock);
    push(tv[6].data, tv[6].frame, 0);
    repeat (4 + 6 * BT + 200) @(negedge clock);
    check("pre_clear_tx", int'(bus.tx), 0);
    fd0 = fd_cnt;
    #1 clear = 1'b1;
    #1;
    check("clear_tx_async", int'(bus.tx), 1);
    check("clear_busy", int'(bus.busy), 0);
    check("clear_frame_done", int'(bus.frame_done), 0);
    repeat (5) @(negedge clock);
    clear = 1'b0;
    repeat (20) @(negedge clock);
    check("clear_no_frame_done", fd_cnt, fd0);
    check("clear_no_retry_busy", int'(bus.busy), 0);
    @(negedge clock);
    p0 = cyc;
    push(tv[0].data, tv[0].frame, 1);
    wait_frames(f0 + 1, "post_clear_frame_seen");
    check("post_clear_latency", last_start - p0, 4);
    check("scoreboard_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rs232_fifo_transmitter.md
RS232_FIFO_TRANSMITTER -- requirements
Module: rs232_fifo_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial line bit rate.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: bits per character.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port clear, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1: permits starting a new frame.
REQ-007 SHALL have port fifo_ready, input, 1: source FIFO is operational.
REQ-008 SHALL have port fifo_empty, input, 1: source FIFO holds no data (popped_last semantics; 1 after FIFO clear).
REQ-009 SHALL have port fifo_data, input, DATA_WIDTH: FIFO output data, valid on the cycle after a pop pulse.
REQ-010 SHALL have port fifo_pop, output, 1: one-cycle pop strobe, which drives the FIFO pop_clock.
REQ-011 SHALL have port tx, output, 1: serial line, idle high.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when a stop bit completes.

Function
REQ-014 SHALL use BIT_TICKS = CLOCK_FREQ/BAUD_RATE (integer division); each serial bit SHALL last exactly BIT_TICKS clock cycles.
REQ-015 SHALL have the states IDLE, POP, LATCH, START, DATA, PARITY, STOP.
REQ-016 IDLE: when enable && fifo_ready && !fifo_empty is sampled, the next state SHALL be POP; otherwise the block SHALL stay in IDLE.
REQ-017 POP: fifo_pop SHALL be 1 for exactly this one cycle, and the next state SHALL be LATCH.
REQ-018 LATCH: fifo_data SHALL be captured into the shift register, the bit counter SHALL be zeroed, and the next state SHALL be START.
REQ-019 START: tx SHALL be 0 for BIT_TICKS cycles, then the next state SHALL be DATA.
REQ-020 DATA: the block SHALL send DATA_WIDTH bits LSB first, each for BIT_TICKS cycles, then go to PARITY if configured, else to STOP.
REQ-021 STOP: tx SHALL be 1 for BIT_TICKS cycles; frame_done SHALL pulse on the last cycle; the next state SHALL be IDLE.
REQ-022 Latency: tx SHALL fall on the third rising edge after the edge that samples the start condition in IDLE.
REQ-023 Back-to-back: with data remaining in the FIFO, the gap between a stop-bit end and the next start bit SHALL be exactly 3 cycles (IDLE, POP, LATCH).
REQ-024 Deasserting enable or fifo_ready mid-frame SHALL NOT abort the frame; it SHALL only block the next IDLE->POP transition.
REQ-025 fifo_empty SHALL be sampled only in IDLE; a change in any other state SHALL have no effect.
REQ-026 The baud counter SHALL be 16 bits, SHALL reset to 0 at each bit boundary, and SHALL never wrap within a bit.

Reset
REQ-027 While clear=1, outputs SHALL be: tx=1, fifo_pop=0, busy=0, frame_done=0; the state SHALL be IDLE and all counters and the shift register SHALL be 0.
REQ-028 A clear asserted mid-frame SHALL force tx=1 immediately (asynchronously); the partial frame SHALL be lost and SHALL NOT be retried.

Configuration
REQ-029 With macro RS232_TX_PARITY_EN defined, the PARITY state SHALL send one even-parity bit (XOR of the data bits) for BIT_TICKS cycles between DATA and STOP.
REQ-030 Without RS232_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; the frame SHALL be 8N1 (10 bits).

Structure
REQ-031 State encodings, the frame constants (start level 0, stop level 1) and the BIT_TICKS computation SHALL live in the shared header rs232_defs, which the RS232 receiver also uses.
REQ-032 Bit timing SHALL be a sub-module baud_tick_generator (parameters CLOCK_FREQ and BAUD_RATE; inputs clock, clear, restart; output tick).

Verification
REQ-033 CLOCK_FREQ=50000000, BAUD_RATE=115200, FIFO holding 0x55 -> one fifo_pop pulse; tx: start 0, bits 1,0,1,0,1,0,1,0, stop 1; each bit 434 cycles; frame_done pulses once.
REQ-034 FIFO holding 0xA3, 0x0F -> two frames with exactly a 3-cycle gap between the first stop bit end and the second start bit; the block then returns to IDLE and fifo_pop stays 0 once fifo_empty=1.
REQ-035 enable dropped at bit 3 of 0xFF -> the frame completes intact; no further pop until enable=1.
REQ-036 clear pulsed during bit 5 -> tx=1 within the same cycle, busy=0, no frame_done; the next frame after clear releases is complete.
REQ-037 With RS232_TX_PARITY_EN defined, sending 0x07 -> parity bit 1 and an 11-bit frame; sending 0x03 -> parity bit 0.
REQ-038 fifo_empty=1 with enable=1 for 10000 cycles -> tx stays 1, fifo_pop stays 0 and busy stays 0.
